// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and default constants for the UART transmit path
//
// Contents:
//   tx_state_t        transmitter FSM state encoding
//   CLKS_PER_BIT_DEF  default clock cycles per serial bit
//   DATA_BITS_DEF     default data bits per frame
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int CLKS_PER_BIT_DEF = 10;
   localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - bit-period counter producing a terminal-count strobe
//
// Ports:
//   clk       system clock, rising edge
//   n_rst     synchronous active-low reset
//   enable    count while high; the count holds while low
//   clear     force the count back to 0 (wins over enable)
//   bit_tick  high during the last cycle of each bit period while enabled
module tx_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic enable,
   input  logic clear,
   output logic bit_tick
);

   // A single-cycle bit period still needs a 1-bit counter; it simply stays 0.
   localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
      end
   end

   assign bit_tick = enable && (cnt == TERM);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter (start, LSB-first data, optional parity, stop)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit.
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       synchronous active-low reset; aborts any frame, line goes high
//   tx_data     byte to send, captured only when a start is accepted
//   tx_start    level request to send; ignored while a frame is in flight
//   serial_out  registered serial line, idles high
//   tx_busy     high from start bit through stop bit
//   tx_done     one-cycle pulse on the edge the stop bit completes
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 serial_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int            IW       = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic [IW-1:0]        bit_idx, idx_next;
   logic                 serial_next;
   logic                 busy_next;
   logic                 done_next;
   logic                 accept;
   logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_next;
`endif

   tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .enable   (state != IDLE),
      .clear    (accept),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_idx    <= '0;
         serial_out <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         shift_reg  <= shift_next;
         bit_idx    <= idx_next;
         serial_out <= serial_next;
         tx_busy    <= busy_next;
         tx_done    <= done_next;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_next;
`endif
      end
   end

   // serial_out is registered, so each branch drives the line value that
   // belongs to the state being entered, not the state being left.
   always_comb begin
      state_next  = state;
      shift_next  = shift_reg;
      idx_next    = bit_idx;
      serial_next = serial_out;
      busy_next   = tx_busy;
      done_next   = 1'b0;
      accept      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next = parity_q;
`endif

      case (state)
         IDLE: begin
            serial_next = 1'b1;
            busy_next   = 1'b0;
            if (tx_start) begin
               accept      = 1'b1;
               shift_next  = tx_data;
               idx_next    = '0;
               state_next  = START;
               serial_next = 1'b0;
               busy_next   = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_next = ^tx_data;
`endif
            end
         end

         START: begin
            if (bit_tick) begin
               state_next  = DATA;
               serial_next = shift_reg[0];
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_next  = PARITY;
                  serial_next = parity_q;
`else
                  state_next  = STOP;
                  serial_next = 1'b1;
`endif
               end else begin
                  // Bit 1 becomes the new LSB, so it is the next line value.
                  shift_next  = shift_reg >> 1;
                  idx_next    = bit_idx + IW'(1);
                  serial_next = shift_reg[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_next  = STOP;
               serial_next = 1'b1;
            end
         end
`endif

         STOP: begin
            if (bit_tick) begin
               state_next  = IDLE;
               serial_next = 1'b1;
               busy_next   = 1'b0;
               done_next   = 1'b1;
            end
         end

         default: begin
            state_next  = IDLE;
            serial_next = 1'b1;
            busy_next   = 1'b0;
         end
      endcase
   end

endmodule
